spi_slave_stream: RTL and testbench
===================================

SPI_SLAVE_STREAM -- requirements
Module: spi_slave_stream

Interface
REQ-001 Parameter DATA_W, default 8, bits per SPI word (legal 4..32).
REQ-002 Parameter CPOL, default 0, SCK idle level.
REQ-003 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1; 1 = MSB first on both lines, 0 = LSB first.
REQ-005 Parameter TX_IDLE, default all-zeros (DATA_W bits), word sent when no TX data is available.
REQ-006 clk  in  1  single system clock; every register changes only on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 SCK, SSEL, MOSI  in  1 each  asynchronous SPI pins; SSEL is active low.
REQ-009 MISO  out  1  serial data out; MISO_OE  out  1  high while the frame is active (tri-state enable).
REQ-010 rx_data  out  DATA_W  received word; rx_valid  out  1; rx_ready  in  1.
REQ-011 tx_data  in  DATA_W  word to send; tx_valid  in  1; tx_ready  out  1.
REQ-012 rx_overrun, tx_underrun, frame_err  out  1 each  single-clk event pulses.

Function
REQ-013 SCK and SSEL SHALL pass through 3-flop synchronisers and MOSI through a 2-flop synchroniser; edges are detected from stages [2:1].
REQ-014 Leading edge = SCK leaving CPOL level, trailing edge = SCK returning to it; sample edge = leading if CPHA=0, else trailing; the other edge is the shift edge.
REQ-015 Frame active = synchronised SSEL low; frame start = its falling edge, frame end = its rising edge.
REQ-016 SCK edges SHALL be ignored while the frame is inactive; SCK half-period is required to be >= 4 clk.
REQ-017 On each sample edge, synchronised MOSI SHALL be shifted into the RX shift register per MSB_FIRST, and bitcnt (0..DATA_W-1) SHALL increment, wrapping to 0 after DATA_W-1.
REQ-018 On the sample edge that completes a word: if rx_valid is low or rx_ready is high, rx_data SHALL take the completed word and rx_valid SHALL be 1 from the next cycle.
REQ-019 If rx_valid=1 and rx_ready=0 at word completion, the new word SHALL be dropped, rx_data kept, and rx_overrun pulsed for one cycle.
REQ-020 rx_valid SHALL clear on the cycle after rx_valid and rx_ready are both high, unless a new word is loaded on that same cycle.
REQ-021 TX path: one-entry holding register; tx_ready = holding register empty; the word is accepted on a clk where tx_valid and tx_ready are both high.
REQ-022 A TX load SHALL occur at frame start for CPHA=0, and at every shift edge with bitcnt==0 for both modes (CPHA=0 loads only after a completed word).
REQ-023 A TX load SHALL move the holding word into the TX shift register and empty the holding register; if the holding register is empty, it SHALL load TX_IDLE and pulse tx_underrun.
REQ-024 All other shift edges SHALL shift the TX register by one bit; MISO SHALL equal the current outgoing bit (MSB if MSB_FIRST, else LSB).
REQ-025 If an accept and a load occur on the same clk, the accepted word SHALL go straight to the shift register and the holding register SHALL stay empty.
REQ-026 At frame end: bitcnt SHALL go to 0 and any partial RX word SHALL be discarded, with frame_err pulsed if bitcnt != 0.
REQ-027 A word loaded by the final CPHA=0 trailing edge and not sent before frame end SHALL be discarded without any flag.
REQ-028 Frame start and frame end in the same clk cannot occur; a frame start while bitcnt != 0 SHALL reset bitcnt to 0.
REQ-029 MISO_OE SHALL equal frame active, taken from the synchronised SSEL.

Reset
REQ-030 When rst=1 on a clk edge, all of the following SHALL be set, and rst SHALL take priority over all other events:
- SCK synchronisers to CPOL, SSEL synchronisers to 1, MOSI synchronisers to 0;
- bitcnt 0, both shift registers 0, holding register empty;
- rx_data 0, rx_valid 0, tx_ready 1, MISO 0, MISO_OE 0, all event pulses 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no frame_err; the first frame start after reset release SHALL behave as a fresh frame.

Verification
REQ-032 Mode 0, DATA_W=8, tx_data=0xA5 preloaded, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1; no flags.
REQ-033 Run all four CPOL/CPHA modes with DATA_W=16, MSB_FIRST=0, two-word frame 0x1234, 0xBEEF -> both words received in order; the MISO stream matches tx words LSB first.
REQ-034 Hold rx_ready=0 and send three words 0x11, 0x22, 0x33 -> rx_data stays 0x11; rx_overrun pulses twice.
REQ-035 No tx_valid, one word sent -> MISO sends TX_IDLE; tx_underrun pulses once.
REQ-036 SSEL rises after 5 of 8 bits -> frame_err pulses; rx_valid stays 0; the next full frame receives correctly.
REQ-037 Assert rst at bit 4 of a frame -> all outputs at reset values next clk; a following frame 0x5A is received with no frame_err.

Source files
------------

// File: rtl/spi_slave_stream.sv
// spi_slave_stream: SPI slave with ready/valid stream interfaces on the system clock side.
//
// The SPI pins are asynchronous to clk. They are synchronised, and SCK/SSEL edges are
// detected on the system clock, so SCK must be much slower than clk.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   SCK, SSEL, MOSI      asynchronous SPI pins (SSEL active low)
//   MISO, MISO_OE        serial data out and its tri-state enable (high while frame active)
//   rx_data/valid/ready  received-word stream (one-word output register)
//   tx_data/valid/ready  transmit-word stream (one-entry holding register)
//   rx_overrun           pulse: completed word dropped because rx_data was still unread
//   tx_underrun          pulse: TX_IDLE loaded because no transmit word was waiting
//   frame_err            pulse: SSEL released in the middle of a word
module spi_slave_stream #(
    parameter int DATA_W    = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1,
    parameter logic [DATA_W-1:0] TX_IDLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCK,
    input  logic              SSEL,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              frame_err
);

    localparam int   CNT_W  = $clog2(DATA_W);
    localparam logic CPOL_L = (CPOL != 0);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [2:0]        sck_sync;
    logic [2:0]        ssel_sync;
    logic [1:0]        mosi_sync;
    logic [CNT_W-1:0]  bitcnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] hold;
    logic              hold_full;

    logic              frame_active;
    logic              frame_start;
    logic              frame_end;
    logic              sck_lead;
    logic              sck_trail;
    logic              sample_edge;
    logic              shift_edge;
    logic              tx_load;
    logic              tx_accept;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shifted;

    // Stage 1 is the newer synchronised value and stage 2 the older one, so MOSI stage 1
    // lines up in time with the SCK edge seen between stages 2 and 1.
    assign frame_active = ~ssel_sync[1];
    assign frame_start  = ssel_sync[2] & ~ssel_sync[1];
    assign frame_end    = ~ssel_sync[2] & ssel_sync[1];

    // SCK edges only count while the frame is active.
    assign sck_lead    = frame_active && (sck_sync[1] != CPOL_L) && (sck_sync[2] == CPOL_L);
    assign sck_trail   = frame_active && (sck_sync[1] == CPOL_L) && (sck_sync[2] != CPOL_L);
    assign sample_edge = (CPHA == 0) ? sck_lead : sck_trail;
    assign shift_edge  = (CPHA == 0) ? sck_trail : sck_lead;

    assign rx_next = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], mosi_sync[1]}
                                      : {mosi_sync[1], rx_shift[DATA_W-1:1]};
    assign tx_shifted = (MSB_FIRST != 0) ? {tx_shift[DATA_W-2:0], 1'b0}
                                         : {1'b0, tx_shift[DATA_W-1:1]};

    // In CPHA=0 the first bit must be on MISO before the first SCK edge, so the first word
    // is loaded at frame start; later words load on the shift edge that follows a
    // completed word (bitcnt has wrapped to 0).
    assign tx_load   = ((CPHA == 0) && frame_start) || (shift_edge && (bitcnt == '0));
    assign tx_accept = tx_valid && !hold_full;

    assign MISO     = (MSB_FIRST != 0) ? tx_shift[DATA_W-1] : tx_shift[0];
    assign MISO_OE  = frame_active;
    assign tx_ready = ~hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync    <= {3{CPOL_L}};
            ssel_sync   <= 3'b111;
            mosi_sync   <= 2'b00;
            bitcnt      <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sck_sync    <= {sck_sync[1:0], SCK};
            ssel_sync   <= {ssel_sync[1:0], SSEL};
            mosi_sync   <= {mosi_sync[0], MOSI};
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            // A consumed word clears rx_valid; a word completing this same cycle
            // overrides this below.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            // Receive side. Frame end drops any partial word.
            if (frame_end) begin
                bitcnt   <= '0;
                rx_shift <= '0;
                if (bitcnt != '0) begin
                    frame_err <= 1'b1;
                end
            end else if (frame_start) begin
                bitcnt <= '0;
            end else if (sample_edge) begin
                rx_shift <= rx_next;
                bitcnt   <= (bitcnt == LAST_BIT) ? '0 : bitcnt + CNT_W'(1);
                if (bitcnt == LAST_BIT) begin
                    if (!rx_valid || rx_ready) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                    end else begin
                        rx_overrun <= 1'b1;
                    end
                end
            end

            // Transmit side. A word accepted in the same cycle as a load with an empty
            // holding register bypasses straight into the shift register.
            if (tx_load) begin
                if (hold_full) begin
                    tx_shift  <= hold;
                    hold_full <= 1'b0;
                end else if (tx_accept) begin
                    tx_shift <= tx_data;
                end else begin
                    tx_shift    <= TX_IDLE;
                    tx_underrun <= 1'b1;
                end
            end else begin
                if (shift_edge) begin
                    tx_shift <= tx_shifted;
                end
                if (tx_accept) begin
                    hold      <= tx_data;
                    hold_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_stream.sv
// tb_spi_slave_stream: directed bench for spi_slave_stream.
// One 8-bit mode-0 MSB-first instance carries the single-word cases; four 16-bit
// LSB-first instances (one per CPOL/CPHA mode) carry the two-word stream case.
module tb_spi_slave_stream;

    localparam int HALF = 6;

    typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} spi_mode_e;

    typedef struct {
        logic [7:0] tx_word;
        logic [7:0] mosi_word;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       sck8, ssel8, mosi8, miso8, miso_oe8;
    logic [7:0] rx_data8, tx_data8;
    logic       rx_valid8, rx_ready8, tx_valid8, tx_ready8;
    logic       rx_overrun8, tx_underrun8, frame_err8;

    // 16-bit instances, index = {CPOL, CPHA}
    logic [3:0]  sck16, ssel16, mosi16, tx_valid16;
    logic        miso16 [4];
    logic        miso_oe16 [4];
    logic [15:0] rx_data16 [4];
    logic [15:0] tx_data16 [4];
    logic        rx_valid16 [4];
    logic        tx_ready16 [4];
    logic        ovr16 [4];
    logic        und16 [4];
    logic        ferr16 [4];
    logic        rx_ready16;

    int checks = 0;
    int errors = 0;

    int ovr8_cnt = 0;
    int und8_cnt = 0;
    int ferr8_cnt = 0;
    logic [15:0] rx_got [4][4];
    int rx_cnt [4] = '{0, 0, 0, 0};

    spi_slave_stream #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut8 (
        .clk(clk), .rst(rst), .SCK(sck8), .SSEL(ssel8), .MOSI(mosi8),
        .MISO(miso8), .MISO_OE(miso_oe8),
        .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ready(rx_ready8),
        .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .rx_overrun(rx_overrun8), .tx_underrun(tx_underrun8), .frame_err(frame_err8)
    );

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_stream #(.DATA_W(16), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(0)) dut16 (
            .clk(clk), .rst(rst), .SCK(sck16[g]), .SSEL(ssel16[g]), .MOSI(mosi16[g]),
            .MISO(miso16[g]), .MISO_OE(miso_oe16[g]),
            .rx_data(rx_data16[g]), .rx_valid(rx_valid16[g]), .rx_ready(rx_ready16),
            .tx_data(tx_data16[g]), .tx_valid(tx_valid16[g]), .tx_ready(tx_ready16[g]),
            .rx_overrun(ovr16[g]), .tx_underrun(und16[g]), .frame_err(ferr16[g])
        );
    end

    // Event pulses are one clk wide, so sampling each posedge counts each pulse once.
    always @(posedge clk) begin
        if (rx_overrun8)  ovr8_cnt  <= ovr8_cnt + 1;
        if (tx_underrun8) und8_cnt  <= und8_cnt + 1;
        if (frame_err8)   ferr8_cnt <= ferr8_cnt + 1;
    end

    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (rx_valid16[g] && rx_ready16 && rx_cnt[g] < 4) begin
                rx_got[g][rx_cnt[g]] <= rx_data16[g];
                rx_cnt[g] <= rx_cnt[g] + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got=%h want=%h", name, actual, expected);
        end
    endtask

    task automatic set_sck(input int inst, input logic v);
        if (inst == 4) sck8 = v; else sck16[inst] = v;
    endtask

    task automatic set_ssel(input int inst, input logic v);
        if (inst == 4) ssel8 = v; else ssel16[inst] = v;
    endtask

    task automatic set_mosi(input int inst, input logic v);
        if (inst == 4) mosi8 = v; else mosi16[inst] = v;
    endtask

    function automatic logic get_miso(input int inst);
        return (inst == 4) ? miso8 : miso16[inst];
    endfunction

    function automatic logic get_tx_ready(input int inst);
        return (inst == 4) ? tx_ready8 : tx_ready16[inst];
    endfunction

    // Bit i of the result is the i-th bit on the wire for up to three MSB-first bytes.
    function automatic logic [63:0] msb_stream(input logic [23:0] ws);
        logic [63:0] r = '0;
        for (int i = 0; i < 24; i++) r[i] = ws[23 - i];
        return r;
    endfunction

    function automatic logic [7:0] msb_word(input logic [63:0] b);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[7 - j] = b[j];
        return w;
    endfunction

    task automatic push_tx(input int inst, input logic [15:0] word);
        bit done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (get_tx_ready(inst)) begin
                if (inst == 4) begin tx_data8 = word[7:0]; tx_valid8 = 1'b1; end
                else begin tx_data16[inst] = word; tx_valid16[inst] = 1'b1; end
                @(negedge clk);
                if (inst == 4) tx_valid8 = 1'b0; else tx_valid16[inst] = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL tx_push_timeout inst=%0d got=no_accept want=accept", inst);
        end
    endtask

    // SPI master. MISO is captured just before the edge on which a master samples it;
    // und_snap holds the 8-bit underrun count just before the final trailing edge.
    task automatic spi_frame(input int inst, input int cpol, input int cpha, input int nbits,
                             input logic [63:0] mosi_bits, input bit raise_ssel,
                             output logic [63:0] miso_bits, output int und_snap);
        miso_bits = '0;
        und_snap  = und8_cnt;
        set_sck(inst, cpol != 0);
        set_ssel(inst, 1'b1);
        repeat (HALF) @(negedge clk);
        set_ssel(inst, 1'b0);
        if (cpha == 0) set_mosi(inst, mosi_bits[0]);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (cpha == 0) begin
                miso_bits[i] = get_miso(inst);
                set_sck(inst, cpol == 0);
                repeat (HALF) @(negedge clk);
                if (i == nbits - 1) und_snap = und8_cnt;
                set_sck(inst, cpol != 0);
                repeat (HALF) @(negedge clk);
                if (i + 1 < nbits) set_mosi(inst, mosi_bits[i + 1]);
            end else begin
                set_sck(inst, cpol == 0);
                set_mosi(inst, mosi_bits[i]);
                repeat (HALF) @(negedge clk);
                miso_bits[i] = get_miso(inst);
                if (i == nbits - 1) und_snap = und8_cnt;
                set_sck(inst, cpol != 0);
                repeat (HALF) @(negedge clk);
            end
        end
        if (raise_ssel) begin
            set_ssel(inst, 1'b1);
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic drain_rx8();
        rx_ready8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rx_valid_cleared", 32'(rx_valid8), 32'd0);
        rx_ready8 = 1'b0;
    endtask

    // One table row: preload TX, run one mode-0 byte, check RX, MISO and flags.
    task automatic applyStimulus(input vec_t v, input int idx);
        logic [63:0] bits;
        int und_snap;
        int ovr0  = ovr8_cnt;
        int und0  = und8_cnt;
        int ferr0 = ferr8_cnt;
        push_tx(4, {8'h00, v.tx_word});
        spi_frame(4, 0, 0, 8, msb_stream({v.mosi_word, 16'h0}), 1'b1, bits, und_snap);
        repeat (2) @(negedge clk);
        checkOutput($sformatf("vec%0d_rx_data", idx), 32'(rx_data8), 32'(v.exp_rx));
        checkOutput($sformatf("vec%0d_rx_valid", idx), 32'(rx_valid8), 32'd1);
        checkOutput($sformatf("vec%0d_miso", idx), 32'(msb_word(bits)), 32'(v.exp_miso));
        checkOutput($sformatf("vec%0d_overrun", idx), 32'(ovr8_cnt - ovr0), 32'd0);
        checkOutput($sformatf("vec%0d_frame_err", idx), 32'(ferr8_cnt - ferr0), 32'd0);
        checkOutput($sformatf("vec%0d_underrun", idx), 32'(und_snap - und0), 32'd0);
        drain_rx8();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [5];
        logic [63:0] bits;
        int und_snap;
        int snap_a;
        int snap_b;

        vecs[0] = '{tx_word: 8'hA5, mosi_word: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5};
        vecs[1] = '{tx_word: 8'h00, mosi_word: 8'hFF, exp_rx: 8'hFF, exp_miso: 8'h00};
        vecs[2] = '{tx_word: 8'hFF, mosi_word: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF};
        vecs[3] = '{tx_word: 8'h5A, mosi_word: 8'h81, exp_rx: 8'h81, exp_miso: 8'h5A};
        vecs[4] = '{tx_word: 8'hC3, mosi_word: 8'h96, exp_rx: 8'h96, exp_miso: 8'hC3};

        rst = 1'b1;
        sck8 = 1'b0; ssel8 = 1'b1; mosi8 = 1'b0;
        tx_data8 = 8'h00; tx_valid8 = 1'b0; rx_ready8 = 1'b0;
        sck16 = 4'b1100; ssel16 = 4'hF; mosi16 = 4'h0; tx_valid16 = 4'h0;
        for (int g = 0; g < 4; g++) tx_data16[g] = 16'h0;
        rx_ready16 = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_rx_valid", 32'(rx_valid8), 32'd0);
        checkOutput("reset_rx_data", 32'(rx_data8), 32'd0);
        checkOutput("reset_tx_ready", 32'(tx_ready8), 32'd1);
        checkOutput("reset_miso_oe", 32'(miso_oe8), 32'd0);
        checkOutput("reset_miso", 32'(miso8), 32'd0);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

        // Overrun: first word held, next two dropped.
        snap_a = ovr8_cnt;
        spi_frame(4, 0, 0, 24, msb_stream(24'h112233), 1'b1, bits, und_snap);
        repeat (2) @(negedge clk);
        checkOutput("overrun_rx_data", 32'(rx_data8), 32'h11);
        checkOutput("overrun_rx_valid", 32'(rx_valid8), 32'd1);
        checkOutput("overrun_count", 32'(ovr8_cnt - snap_a), 32'd2);
        drain_rx8();

        // Underrun: nothing queued, TX_IDLE goes out.
        snap_a = und8_cnt;
        spi_frame(4, 0, 0, 8, msb_stream({8'h6B, 16'h0}), 1'b1, bits, und_snap);
        repeat (2) @(negedge clk);
        checkOutput("underrun_miso", 32'(msb_word(bits)), 32'h00);
        checkOutput("underrun_count", 32'(und_snap - snap_a), 32'd1);
        checkOutput("underrun_rx_data", 32'(rx_data8), 32'h6B);
        drain_rx8();

        // Frame error: SSEL released after 5 bits, then a clean frame.
        snap_a = ferr8_cnt;
        spi_frame(4, 0, 0, 5, msb_stream({8'hB7, 16'h0}), 1'b1, bits, und_snap);
        repeat (2) @(negedge clk);
        checkOutput("short_frame_err", 32'(ferr8_cnt - snap_a), 32'd1);
        checkOutput("short_rx_valid", 32'(rx_valid8), 32'd0);
        spi_frame(4, 0, 0, 8, msb_stream({8'h96, 16'h0}), 1'b1, bits, und_snap);
        repeat (2) @(negedge clk);
        checkOutput("after_err_rx_data", 32'(rx_data8), 32'h96);
        checkOutput("after_err_rx_valid", 32'(rx_valid8), 32'd1);
        checkOutput("after_err_frame_err", 32'(ferr8_cnt - snap_a), 32'd1);
        drain_rx8();

        // Four SPI modes, 16-bit LSB-first, two-word frame.
        for (int m = 0; m < 4; m++) begin
            spi_mode_e mode = spi_mode_e'(m);
            fork
                begin
                    push_tx(m, 16'h1234);
                    push_tx(m, 16'hBEEF);
                end
                spi_frame(m, m / 2, m % 2, 32, 64'h0000_0000_BEEF_1234, 1'b1, bits, und_snap);
            join
            repeat (4) @(negedge clk);
            checkOutput($sformatf("%s_rx_count", mode.name()), 32'(rx_cnt[m]), 32'd2);
            checkOutput($sformatf("%s_rx_word0", mode.name()), 32'(rx_got[m][0]), 32'h1234);
            checkOutput($sformatf("%s_rx_word1", mode.name()), 32'(rx_got[m][1]), 32'hBEEF);
            checkOutput($sformatf("%s_miso", mode.name()), bits[31:0], 32'hBEEF1234);
        end

        // Reset in the middle of a frame.
        spi_frame(4, 0, 0, 8, msb_stream({8'h77, 16'h0}), 1'b1, bits, und_snap);
        repeat (2) @(negedge clk);
        snap_b = ferr8_cnt;
        spi_frame(4, 0, 0, 4, msb_stream({8'hE1, 16'h0}), 1'b0, bits, und_snap);
        push_tx(4, 16'h00C3);
        checkOutput("pre_reset_miso_oe", 32'(miso_oe8), 32'd1);
        checkOutput("pre_reset_rx_valid", 32'(rx_valid8), 32'd1);
        checkOutput("pre_reset_tx_ready", 32'(tx_ready8), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_rx_valid", 32'(rx_valid8), 32'd0);
        checkOutput("mid_reset_rx_data", 32'(rx_data8), 32'd0);
        checkOutput("mid_reset_tx_ready", 32'(tx_ready8), 32'd1);
        checkOutput("mid_reset_miso", 32'(miso8), 32'd0);
        checkOutput("mid_reset_miso_oe", 32'(miso_oe8), 32'd0);
        checkOutput("mid_reset_flags", 32'({rx_overrun8, tx_underrun8, frame_err8}), 32'd0);
        ssel8 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        spi_frame(4, 0, 0, 8, msb_stream({8'h5A, 16'h0}), 1'b1, bits, und_snap);
        repeat (2) @(negedge clk);
        checkOutput("post_reset_rx_data", 32'(rx_data8), 32'h5A);
        checkOutput("post_reset_rx_valid", 32'(rx_valid8), 32'd1);
        checkOutput("post_reset_frame_err", 32'(ferr8_cnt - snap_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
